text_pixel_renderer: RTL and testbench
======================================

Name: text_pixel_renderer

Overview:
- Display-side consumer of the on-chip VRAM in the VGA text-mode core.
- Takes DrawX/DrawY from the VGA sync generator and reads character words from the VRAM read port during cycles in which the VRAM state controller asserts getchar.
- Looks up glyph rows in the 8x16 font ROM and drives the 4-bit RGB pixel outputs through a fixed 3-cycle pipeline.
- Keeps a one-word cache so the pixel stream survives getchar-low (Avalon access) cycles, and flags underruns.

Parameters:
COLS, 80, characters per text row
ADDR_W, 10, VRAM word address width (4 chars per 32-bit word)

Ports:
Clk  in  1  pixel clock; all state on rising edge
RESET  in  1  synchronous, active-high
DrawX  in  10  current pixel column from sync generator
DrawY  in  10  current pixel row
blank_n  in  1  1 = visible pixel
getchar  in  1  VRAM read port granted to renderer this cycle
vram_rdata  in  32  VRAM read data, valid 1 cycle after vram_rd
font_data  in  8  font ROM row, valid 1 cycle after font_addr; bit7 = leftmost pixel
fg_color  in  12  foreground {R,G,B} 4 bits each
bg_color  in  12  background {R,G,B}
clr_underrun  in  1  clears sticky underrun flag
vram_rd  out  1  VRAM read strobe
vram_addr  out  ADDR_W  VRAM word address
font_addr  out  11  {char code[6:0], glyph row[3:0]}
red, green, blue  out  4 each  pixel colour
blank_n_out  out  1  blank_n delayed to align with RGB
underrun  out  1  sticky: a visible pixel had no character data

Behaviour:
- Reset: all pipeline registers 0, red/green/blue 0, blank_n_out 0, underrun 0, cache_valid 0.
- S1, registered from inputs each cycle:
  - index = DrawY[9:4]*COLS + DrawX[9:3], computed 12 bits wide with no saturation.
  - waddr = index[11:2] and bsel = index[1:0] (byte 0 = bits 7:0).
  - grow = DrawY[3:0], bitsel = DrawX[2:0], blank_n.
- S1 outputs:
  - vram_addr = waddr_s1, combinational from the S1 register.
  - vram_rd = getchar. Every granted cycle issues a read; no request/ack.
- S2, word selection:
  - rd_s2 = registered vram_rd.
  - If rd_s2 = 1: use vram_rdata, and load cache_word/cache_addr/cache_valid with {vram_rdata, waddr_s2, 1}.
  - Else if cache_valid and cache_addr == waddr_s2: use cache_word.
  - Else: miss = 1.
  - Selected byte: bit7 = invert, [6:0] = code.
  - font_addr = {code, grow_s2}, combinational.
  - If miss = 1 and blank_n_s2 = 1, set underrun, and it stays set.
- S3, output register:
  - pix = (font_data[7 - bitsel_s3] XOR invert_s3) AND NOT miss_s3.
  - RGB <= blank_n_s3 ? (pix ? fg_color : bg_color) : 0. A miss therefore shows bg_color.
  - blank_n_out <= blank_n_s3.
- Latency: inputs sampled at edge n produce RGB at edge n+3, exactly, independent of getchar.
- fg_color/bg_color are sampled at the S3 register, with no pipelining.
- Simultaneous set and clear of underrun: set wins.
- clr_underrun alone: underrun = 0 on the next edge.
- RESET mid-frame:
  - Pipeline flushed; cache invalidated.
  - First valid RGB appears 3 cycles after RESET deasserts; earlier outputs are 0.
- Cache hit is only on an exact address match. Words change every 32 pixels; a new word with getchar low results in a miss.
- Out-of-range DrawY (>= 480) while blank_n = 0: the address wraps naturally, output is black, and no underrun is raised.

Test Plan:
1. Reset, then hold getchar=1 and sweep DrawX 0..7 at DrawY=0, with VRAM word 0 = 0x00000041 and font row 0 of 'A' = 0x18. Required: RGB pixels bg,bg,bg,fg,fg,bg,bg,bg, each appearing 3 cycles after its DrawX.
2. Same as 1 but byte 0 = 0xC1 (invert set). Required: the pixel pattern is inverted (fg,fg,fg,bg,bg,fg,fg,fg).
3. DrawX=8..15 at DrawY=17 (cy=1, grow=1, index=81). Required: vram_addr = 20, bsel = 1, font_addr = {code, 4'd1}.
4. getchar=1 for DrawX 0..3, then getchar=0 for DrawX 4..31. Required: the cache supplies word 0 (no miss, underrun stays 0). Then DrawX=32 with getchar=0: bg output, and underrun=1 with blank_n=1.
5. Assert clr_underrun on the same cycle as a new miss. Required: underrun remains 1. Then clr_underrun alone: underrun = 0.
6. Assert RESET for 1 cycle mid-line, with the pipeline full. Required: RGB and blank_n_out are 0 for the next 3 cycles, cache_valid = 0 (a first access with getchar=0 misses), and underrun = 0.

Source files
------------

// File: rtl/text_pixel_renderer_if.sv
// Memory-side port bundle of the text renderer: VRAM read port plus font ROM port.
interface text_pixel_renderer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              getchar;
    logic              vram_rd;
    logic [ADDR_W-1:0] vram_addr;
    logic [31:0]       vram_rdata;
    logic [10:0]       font_addr;
    logic [7:0]        font_data;

    modport master (
        input  getchar, vram_rdata, font_data,
        output vram_rd, vram_addr, font_addr
    );

    modport slave (
        output getchar, vram_rdata, font_data,
        input  vram_rd, vram_addr, font_addr
    );
endinterface

// File: rtl/text_pixel_renderer.sv
// Text-mode pixel renderer: DrawX/DrawY -> VRAM character word -> font row -> RGB,
// a fixed three-stage pipeline with a one-word cache covering getchar-low cycles.
module text_pixel_renderer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                  Clk,
    input  logic                  RESET,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic                  blank_n,
    input  logic [11:0]           fg_color,
    input  logic [11:0]           bg_color,
    input  logic                  clr_underrun,
    text_pixel_renderer_if.master bus,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  blank_n_out,
    output logic                  underrun
);

    typedef struct packed {
        logic [9:0] waddr;
        logic [1:0] bsel;
        logic [3:0] grow;
        logic [2:0] bitsel;
        logic       blank_n;
    } pix_ctx_t;

    pix_ctx_t    s1_d, s1_q, s2_d, s2_q;
    logic        rd_s2_d, rd_s2_q;
    logic        invert_s3_d, invert_s3_q;
    logic        miss_s3_d, miss_s3_q;
    logic [2:0]  bitsel_s3_d, bitsel_s3_q;
    logic        blank_s3_d, blank_s3_q;
    logic [31:0] cache_word_d, cache_word_q;
    logic [9:0]  cache_addr_d, cache_addr_q;
    logic        cache_valid_d, cache_valid_q;
    logic [11:0] rgb_d, rgb_q;
    logic        blank_out_d, blank_out_q;
    logic        underrun_d, underrun_q;

    logic [11:0] index;
    logic [31:0] word;
    logic [7:0]  sel_byte;
    logic        miss;
    logic        pix;

    always_comb begin
        // Character index wraps at 12 bits; rows past the visible area just alias.
        index = 12'(32'(DrawY[9:4]) * COLS + 32'(DrawX[9:3]));
        s1_d  = '{waddr: index[11:2], bsel: index[1:0], grow: DrawY[3:0],
                  bitsel: DrawX[2:0], blank_n: blank_n};

        s2_d          = s1_q;
        rd_s2_d       = bus.vram_rd;
        cache_word_d  = cache_word_q;
        cache_addr_d  = cache_addr_q;
        cache_valid_d = cache_valid_q;
        word          = cache_word_q;
        miss          = 1'b0;
        if (rd_s2_q) begin
            word          = bus.vram_rdata;
            cache_word_d  = bus.vram_rdata;
            cache_addr_d  = s2_q.waddr;
            cache_valid_d = 1'b1;
        end else if (!cache_valid_q || cache_addr_q != s2_q.waddr) begin
            miss = 1'b1;
        end
        sel_byte = word[{s2_q.bsel, 3'b000} +: 8];

        // Set has priority so a clear racing a fresh underrun cannot hide it.
        underrun_d = underrun_q;
        if (miss && s2_q.blank_n) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end

        invert_s3_d = sel_byte[7];
        miss_s3_d   = miss;
        bitsel_s3_d = s2_q.bitsel;
        blank_s3_d  = s2_q.blank_n;

        pix   = (bus.font_data[~bitsel_s3_q] ^ invert_s3_q) & ~miss_s3_q;
        rgb_d = '0;
        if (blank_s3_q) begin
            rgb_d = pix ? fg_color : bg_color;
        end
        blank_out_d = blank_s3_q;
    end

    // NOTE: the cache word is a plain register rather than a RAM, so it is cleared
    // with the rest of the pipeline and never leaks X into the first frame.
    always_ff @(posedge Clk) begin
        if (RESET) begin
            s1_q          <= '0;
            s2_q          <= '0;
            rd_s2_q       <= 1'b0;
            invert_s3_q   <= 1'b0;
            miss_s3_q     <= 1'b0;
            bitsel_s3_q   <= '0;
            blank_s3_q    <= 1'b0;
            cache_word_q  <= '0;
            cache_addr_q  <= '0;
            cache_valid_q <= 1'b0;
            rgb_q         <= '0;
            blank_out_q   <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            rd_s2_q       <= rd_s2_d;
            invert_s3_q   <= invert_s3_d;
            miss_s3_q     <= miss_s3_d;
            bitsel_s3_q   <= bitsel_s3_d;
            blank_s3_q    <= blank_s3_d;
            cache_word_q  <= cache_word_d;
            cache_addr_q  <= cache_addr_d;
            cache_valid_q <= cache_valid_d;
            rgb_q         <= rgb_d;
            blank_out_q   <= blank_out_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.vram_rd        = bus.getchar;
    assign bus.vram_addr      = ADDR_W'(s1_q.waddr);
    assign bus.font_addr      = {sel_byte[6:0], s2_q.grow};
    assign {red, green, blue} = rgb_q;
    assign blank_n_out        = blank_out_q;
    assign underrun           = underrun_q;

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Bench for text_pixel_renderer: directed scenarios then random raster traffic,
// each cycle compared against a pixel-level model of the text display.
module tb_text_pixel_renderer;
    localparam int COLS   = 80;
    localparam int ADDR_W = 10;
    localparam int NSTEP  = 2048;

    logic        Clk = 1'b0;
    logic        RESET = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        blank_n = 1'b0;
    logic [11:0] fg_color = 12'hFA5;
    logic [11:0] bg_color = 12'h03C;
    logic        clr_underrun = 1'b0;
    logic [3:0]  red, green, blue;
    logic        blank_n_out;
    logic        underrun;

    text_pixel_renderer_if #(.ADDR_W(ADDR_W)) bus ();

    text_pixel_renderer #(.COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .Clk          (Clk),
        .RESET        (RESET),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .blank_n      (blank_n),
        .fg_color     (fg_color),
        .bg_color     (bg_color),
        .clr_underrun (clr_underrun),
        .bus          (bus),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .blank_n_out  (blank_n_out),
        .underrun     (underrun)
    );

    always #5 Clk = ~Clk;

    // Memories behind the port: one-cycle read latency each.
    logic [31:0] vram [1024];
    logic [7:0]  font [2048];
    always @(posedge Clk) begin
        if (bus.vram_rd) bus.vram_rdata <= vram[bus.vram_addr];
        bus.font_data <= font[bus.font_addr];
    end

    // Per-step history: inputs driven at step k are sampled at clock edge k.
    int          h_x     [NSTEP];
    int          h_y     [NSTEP];
    logic        h_b     [NSTEP];
    logic        h_g     [NSTEP];
    logic        h_valid [NSTEP];
    logic        h_miss  [NSTEP];
    logic        h_pix   [NSTEP];
    int          h_faddr [NSTEP];
    logic [11:0] act_rgb [NSTEP];

    int          m;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        cv;
    int          ca;
    logic [31:0] cw;
    logic        und_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        assert (obs === expected) else begin
            n_fail++;
            $error("FAIL %s (step %0d): observed %0h, expected %0h", tag, m, obs, expected);
        end
    endtask

    function automatic int waddr_of(input int x, input int y);
        return (((y / 16) * COLS + x / 8) % 4096) / 4;
    endfunction

    // Pixel k sits at address waddr; its word is read only if getchar was high one
    // cycle after its coordinates were presented, otherwise the last read word is reused.
    task automatic model_pixel(input int k);
        int idx, wa, bs, code, row, fbyte, inv, bitv;
        logic [31:0] w;
        idx = ((h_y[k] / 16) * COLS + h_x[k] / 8) % 4096;
        wa  = idx / 4;
        bs  = idx % 4;
        w   = '0;
        h_miss[k] = 1'b0;
        if (h_g[k + 1]) begin
            w  = vram[wa];
            cv = 1'b1;
            ca = wa;
            cw = w;
        end else if (cv && ca == wa) begin
            w = cw;
        end else begin
            h_miss[k] = 1'b1;
        end
        code  = int'((w >> (8 * bs)) & 32'h7F);
        inv   = int'((w >> (8 * bs + 7)) & 32'h1);
        row   = h_y[k] % 16;
        h_faddr[k] = code * 16 + row;
        fbyte = int'(font[code * 16 + row]);
        bitv  = (fbyte >> (7 - h_x[k] % 8)) & 1;
        h_pix[k] = !h_miss[k] && ((bitv ^ inv) == 1);
    endtask

    task automatic step(input int x, input int y, input logic b, input logic g,
                        input logic c, input logic rst);
        logic [11:0] exp_rgb;
        logic        exp_blank;
        @(negedge Clk);
        DrawX        = 10'(x);
        DrawY        = 10'(y);
        blank_n      = b;
        bus.getchar  = g;
        clr_underrun = c;
        RESET        = rst;
        h_x[m] = x;
        h_y[m] = y;
        h_b[m] = b;
        h_g[m] = g;
        @(posedge Clk);
        #1;
        if (rst) begin
            for (int k = m - 3; k <= m; k++) h_valid[k] = 1'b0;
            cv    = 1'b0;
            und_m = 1'b0;
        end else begin
            h_valid[m] = 1'b1;
            if (h_valid[m - 1]) model_pixel(m - 1);
            if (h_valid[m - 2] && h_miss[m - 2] && h_b[m - 2]) und_m = 1'b1;
            else if (c) und_m = 1'b0;
        end
        exp_blank = h_valid[m - 3] && h_b[m - 3];
        exp_rgb   = exp_blank ? (h_pix[m - 3] ? fg_color : bg_color) : 12'h000;
        act_rgb[m - 3] = {red, green, blue};
        check("rgb", {20'h0, red, green, blue}, {20'h0, exp_rgb});
        check("blank_n_out", 32'(blank_n_out), 32'(exp_blank));
        check("underrun", 32'(underrun), 32'(und_m));
        check("vram_addr", 32'(bus.vram_addr), rst ? 32'd0 : 32'(waddr_of(x, y)));
        if (!rst && h_valid[m - 1] && !h_miss[m - 1])
            check("font_addr", 32'(bus.font_addr), 32'(h_faddr[m - 1]));
        m++;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] pat_inv;
        int s, p32, r1, x, y;

        bus.getchar = 1'b0;
        for (int k = 0; k < NSTEP; k++) h_valid[k] = 1'b0;
        for (int k = 0; k < 1024; k++) vram[k] = $urandom;
        for (int k = 0; k < 2048; k++) font[k] = 8'($urandom);
        vram[0]          = 32'h0000_0041;
        font[16'h41 * 16] = 8'h18;
        pat     = 8'h18;
        pat_inv = 8'hE7;
        m  = 3;
        cv = 1'b0;
        ca = 0;
        cw = '0;
        und_m = 1'b0;

        // Reset, then 'A' row 0 swept across one character cell.
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        s = m;
        for (int i = 0; i < 8; i++) step(i, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(8, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            check("t1_glyph", 32'(act_rgb[s + i]), 32'(pat[7 - i] ? fg_color : bg_color));

        // Inverse-video attribute bit.
        vram[0] = 32'h0000_00C1;
        s = m;
        for (int i = 0; i < 8; i++) step(i, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(8, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            check("t2_invert", 32'(act_rgb[s + i]), 32'(pat_inv[7 - i] ? fg_color : bg_color));

        // Row 1, column 1: index 81 -> word 20, byte 1, glyph row 1.
        step(8, 17, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_vram_addr", 32'(bus.vram_addr), 32'd20);
        step(9, 17, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_font_addr", 32'(bus.font_addr), 32'({vram[20][14:8], 4'd1}));
        for (int i = 10; i < 16; i++) step(i, 17, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(16, 17, 1'b0, 1'b1, 1'b0, 1'b0);

        // Cache carries word 0 through getchar-low cycles; word 1 then misses.
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        s = m;
        for (int i = 0; i < 4; i++) step(i, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i < 32; i++) step(i, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        p32 = m;
        step(32, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(33, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_no_underrun", 32'(underrun), 32'd0);
        step(34, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_underrun", 32'(underrun), 32'd1);
        step(35, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_miss_bg", 32'(act_rgb[p32]), 32'(bg_color));
        for (int i = 4; i < 8; i++)
            check("t4_cached", 32'(act_rgb[s + i]), 32'(pat_inv[7 - i] ? fg_color : bg_color));

        // Clear racing a fresh miss, then clear alone.
        step(64, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_set_wins", 32'(underrun), 32'd1);
        step(0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_clear", 32'(underrun), 32'd0);

        // Mid-line reset with a full pipeline and underrun pending.
        step(64, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(i, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(8, 0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t6_rst_rgb", 32'({red, green, blue}), 32'd0);
        check("t6_rst_underrun", 32'(underrun), 32'd0);
        r1 = m;
        for (int i = 0; i < 3; i++) begin
            step(i, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("t6_flush_rgb", 32'({red, green, blue}), 32'd0);
            check("t6_flush_blank", 32'(blank_n_out), 32'd0);
        end
        step(3, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_cache_cold", 32'(act_rgb[r1]), 32'(bg_color));
        check("t6_cold_underrun", 32'(underrun), 32'd1);

        // Random raster traffic with sparse grants, clears, colour changes and resets.
        x = 0;
        y = $urandom_range(0, 524);
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                fg_color = 12'($urandom);
                bg_color = 12'($urandom);
            end
            step(x, y, (x < 640 && y < 480), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
            x++;
            if (x == 800 || $urandom_range(0, 79) == 0) begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
            end
        end
        repeat (4) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
